// File: rtl/riscv_dmem_ctrl_if.sv
// Request/response and RAM-side bundle for riscv_dmem_ctrl.
// slave = controller side, master = requesters plus RAM.
interface riscv_dmem_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [5:0]        req_funct3;
  logic [63:0]       req_addr;
  logic [63:0]       req_wdata;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, ram_dout,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, ram_we, ram_addr, ram_din
  );

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, ram_dout,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/riscv_dmem_ctrl.sv
// Round-robin two-port controller for the single-port data RAM,
// with byte-lane stores and sign/zero-extended loads.
module riscv_dmem_ctrl #(
  parameter int ADDR_W = 14
) (
  input logic               clk,
  input logic               rst,
  riscv_dmem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e            state_q;
  logic              last_q;
  logic              owner_q;
  logic              store_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic [1:0]        rsp_valid_q;
  logic              rsp_err_q;
  logic [3:0]        ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [31:0]       ram_din_q;

  logic [1:0]  gnt;
  logic        g;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic [2:0]  g_f3;
  logic        g_we;
  logic        g_bad;
  logic [3:0]  g_lanes;
  logic [31:0] g_din;
  logic [31:0] sel;
  logic [31:0] fmt;

  // Tie goes to the port that did not win last time.
  always_comb begin
    gnt = 2'b00;
    if (state_q == IDLE) begin
      unique case (bus.req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign g       = gnt[1];
  assign g_addr  = g ? bus.req_addr[63:32]  : bus.req_addr[31:0];
  assign g_wdata = g ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
  assign g_f3    = g ? bus.req_funct3[5:3]  : bus.req_funct3[2:0];
  assign g_we    = g ? bus.req_we[1]        : bus.req_we[0];

  assign bus.req_ready = gnt;

  always_comb begin
    g_bad = 1'b0;
    if (g_we && (g_f3[2] || g_f3[1:0] == 2'b11))
      g_bad = 1'b1;
    if (!g_we && (g_f3 == 3'b011 || g_f3[2:1] == 2'b11))
      g_bad = 1'b1;
    if (g_f3[1:0] == 2'b01 && g_addr[0])
      g_bad = 1'b1;
    if (g_f3[1:0] == 2'b10 && g_addr[1:0] != 2'b00)
      g_bad = 1'b1;
    if (g_addr[31:ADDR_W+2] != '0)
      g_bad = 1'b1;
  end

  always_comb begin
    g_lanes = 4'b0000;
    g_din   = g_wdata;
    if (g_we) begin
      unique case (g_f3[1:0])
        2'b00: begin
          g_lanes = 4'b0001 << g_addr[1:0];
          g_din   = {4{g_wdata[7:0]}};
        end
        2'b01: begin
          g_lanes = 4'b0011 << g_addr[1:0];
          g_din   = {2{g_wdata[15:0]}};
        end
        default: g_lanes = 4'b1111;
      endcase
    end
  end

  assign sel = bus.ram_dout >> {off_q, 3'b000};

  always_comb begin
    fmt = sel;
    unique case (f3_q)
      3'b000:  fmt = {{24{sel[7]}}, sel[7:0]};
      3'b100:  fmt = {24'b0, sel[7:0]};
      3'b001:  fmt = {{16{sel[15]}}, sel[15:0]};
      3'b101:  fmt = {16'b0, sel[15:0]};
      default: fmt = sel;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      store_q     <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_addr_q  <= '0;
      ram_din_q   <= 32'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            last_q  <= g;
            owner_q <= g;
            store_q <= g_we;
            f3_q    <= g_f3;
            off_q   <= g_addr[1:0];
            if (g_bad) begin
              state_q     <= RESP;
              rsp_valid_q <= gnt;
              rsp_err_q   <= 1'b1;
            end else begin
              state_q    <= ACCESS;
              ram_we_q   <= g_lanes;
              ram_addr_q <= g_addr[ADDR_W+1:2];
              if (g_we)
                ram_din_q <= g_din;
            end
          end
        end
        ACCESS: begin
          state_q     <= RESP;
          ram_we_q    <= 4'b0000;
          rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
          rsp_err_q   <= 1'b0;
        end
        RESP: begin
          state_q     <= IDLE;
          rsp_valid_q <= 2'b00;
          rsp_err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  // RAM data arrives during RESP, so formatting stays combinational.
  assign bus.rsp_rdata =
    (|rsp_valid_q && !rsp_err_q && !store_q) ? fmt : 32'b0;

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Randomised self-checking bench for riscv_dmem_ctrl against
// a byte-addressed memory model.
module tb_riscv_dmem_ctrl;

  localparam int ADDR_W = 14;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err = 0;

  logic [31:0] obs_rdata;
  logic        obs_err;
  logic [3:0]  obs_we;
  logic [31:0] obs_din;
  logic [13:0] obs_addr;

  logic [31:0] ram  [16384];
  logic [7:0]  gmem [65536];

  riscv_dmem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  riscv_dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (bus.ram_we[i])
        ram[bus.ram_addr][8*i +: 8] <= bus.ram_din[8*i +: 8];
    bus.ram_dout <= ram[bus.ram_addr];
  end

  function automatic bit illegal(bit we, logic [2:0] f3,
                                 logic [31:0] a);
    int sz;
    if (we && f3 > 3'd2) return 1'b1;
    if (!we && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    sz = 1 << f3[1:0];
    if ((a % sz) != 0) return 1'b1;
    if (a >= 32'h10000) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(logic [2:0] f3,
                                           logic [31:0] a);
    int sz;
    logic [31:0] v;
    sz = 1 << f3[1:0];
    v = 32'b0;
    for (int i = 0; i < sz; i++)
      v |= 32'(gmem[a + i]) << (8 * i);
    if (!f3[2] && sz < 4 && v[8*sz-1])
      v |= 32'hFFFF_FFFF << (8 * sz);
    return v;
  endfunction

  task automatic apply_reset;
    bus.req_valid = 2'b00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_req(input int p, input bit we,
                        input logic [2:0] f3,
                        input logic [31:0] a,
                        input logic [31:0] wd);
    bit got;
    bit bad;
    int sz;
    logic [1:0]  ev;
    logic [3:0]  xwe;
    logic [31:0] xdin;
    logic [31:0] xld;
    bad = illegal(we, f3, a);
    sz  = 1 << f3[1:0];
    ev  = 2'(1 << p);
    xwe = we ? 4'(((1 << sz) - 1) << a[1:0]) : 4'b0000;
    xdin = (sz == 1) ? {4{wd[7:0]}} :
           (sz == 2) ? {2{wd[15:0]}} : wd;
    xld = (we || bad) ? 32'b0 : exp_load(f3, a);
    @(negedge clk);
    bus.req_valid[p] = 1'b1;
    bus.req_we[p] = we;
    bus.req_funct3[3*p +: 3] = f3;
    bus.req_addr[32*p +: 32] = a;
    bus.req_wdata[32*p +: 32] = wd;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus.req_ready[p]) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!got) begin
      n_err++;
      $display("FAIL hs_timeout: port %0d no ready", p);
      bus.req_valid[p] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid[p] = 1'b0;
    @(negedge clk);
    obs_we = bus.ram_we;
    obs_din = bus.ram_din;
    obs_addr = bus.ram_addr;
    if (bad) begin
      n_checks++;
      if (bus.rsp_valid !== ev) begin
        n_err++;
        $display("FAIL e_vld: got %b exp %b", bus.rsp_valid, ev);
      end
      n_checks++;
      if (bus.rsp_err !== 1'b1) begin
        n_err++;
        $display("FAIL e_err: got %b exp 1", bus.rsp_err);
      end
      n_checks++;
      if (bus.rsp_rdata !== 32'b0) begin
        n_err++;
        $display("FAIL e_rdata: got %h exp 0", bus.rsp_rdata);
      end
      n_checks++;
      if (bus.ram_we !== 4'b0) begin
        n_err++;
        $display("FAIL e_we: got %b exp 0000", bus.ram_we);
      end
      obs_rdata = bus.rsp_rdata;
      obs_err = bus.rsp_err;
    end else begin
      n_checks++;
      if (bus.rsp_valid !== 2'b00) begin
        n_err++;
        $display("FAIL a_vld: got %b exp 00", bus.rsp_valid);
      end
      n_checks++;
      if (bus.ram_we !== xwe) begin
        n_err++;
        $display("FAIL a_we: got %b exp %b", bus.ram_we, xwe);
      end
      n_checks++;
      if (bus.ram_addr !== a[15:2]) begin
        n_err++;
        $display("FAIL a_addr: got %h exp %h", bus.ram_addr, a[15:2]);
      end
      if (we) begin
        n_checks++;
        if (bus.ram_din !== xdin) begin
          n_err++;
          $display("FAIL a_din: got %h exp %h", bus.ram_din, xdin);
        end
      end
    end
    @(negedge clk);
    if (bad) begin
      n_checks++;
      if (bus.rsp_valid !== 2'b00 || bus.ram_we !== 4'b0) begin
        n_err++;
        $display("FAIL e_after: vld %b we %b exp 00/0000",
                 bus.rsp_valid, bus.ram_we);
      end
    end else begin
      n_checks++;
      if (bus.rsp_valid !== ev) begin
        n_err++;
        $display("FAIL r_vld: got %b exp %b", bus.rsp_valid, ev);
      end
      n_checks++;
      if (bus.rsp_err !== 1'b0) begin
        n_err++;
        $display("FAIL r_err: got %b exp 0", bus.rsp_err);
      end
      n_checks++;
      if (bus.rsp_rdata !== xld) begin
        n_err++;
        $display("FAIL r_rdata: f3 %0d a %h got %h exp %h",
                 f3, a, bus.rsp_rdata, xld);
      end
      n_checks++;
      if (bus.ram_we !== 4'b0) begin
        n_err++;
        $display("FAIL r_we: got %b exp 0000", bus.ram_we);
      end
      obs_rdata = bus.rsp_rdata;
      obs_err = bus.rsp_err;
      if (we)
        for (int i = 0; i < sz; i++)
          gmem[a + i] = wd[8*i +: 8];
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 2'b0 || bus.rsp_err !== 1'b0 ||
        bus.rsp_rdata !== 32'b0 || bus.ram_we !== 4'b0 ||
        bus.ram_addr !== 14'b0 || bus.ram_din !== 32'b0 ||
        bus.req_ready !== 2'b0) begin
      n_err++;
      $display("FAIL reset_out: vld %b err %b rd %h we %b a %h d %h rdy %b",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.ram_we,
               bus.ram_addr, bus.ram_din, bus.req_ready);
    end
    apply_reset;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00) begin
      n_err++;
      $display("FAIL idle_ready: got %b exp 00", bus.req_ready);
    end
  endtask

  task automatic test_store_load;
    do_req(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    n_checks++;
    if (obs_we !== 4'b1111 || obs_addr !== 14'd4) begin
      n_err++;
      $display("FAIL sw_bus: we %b addr %h exp 1111/4", obs_we, obs_addr);
    end
    do_req(0, 1'b0, 3'd2, 32'h10, 32'h0);
    n_checks++;
    if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0) begin
      n_err++;
      $display("FAIL lw_data: got %h/%b exp deadbeef/0", obs_rdata, obs_err);
    end
  endtask

  task automatic test_extract;
    do_req(1, 1'b1, 3'd2, 32'h10, 32'h80FF7F01);
    do_req(0, 1'b0, 3'd0, 32'h12, 32'h0);
    n_checks++;
    if (obs_rdata !== 32'hFFFFFFFF) begin
      n_err++;
      $display("FAIL lb: got %h exp ffffffff", obs_rdata);
    end
    do_req(1, 1'b0, 3'd4, 32'h13, 32'h0);
    n_checks++;
    if (obs_rdata !== 32'h00000080) begin
      n_err++;
      $display("FAIL lbu: got %h exp 00000080", obs_rdata);
    end
    do_req(0, 1'b0, 3'd1, 32'h10, 32'h0);
    n_checks++;
    if (obs_rdata !== 32'h00007F01) begin
      n_err++;
      $display("FAIL lh: got %h exp 00007f01", obs_rdata);
    end
    do_req(1, 1'b0, 3'd5, 32'h12, 32'h0);
    n_checks++;
    if (obs_rdata !== 32'h000080FF) begin
      n_err++;
      $display("FAIL lhu: got %h exp 000080ff", obs_rdata);
    end
    do_req(0, 1'b1, 3'd0, 32'h11, 32'h000000AB);
    n_checks++;
    if (obs_we !== 4'b0010 || obs_din !== 32'hABABABAB) begin
      n_err++;
      $display("FAIL sb: we %b din %h exp 0010/abababab", obs_we, obs_din);
    end
    do_req(1, 1'b1, 3'd1, 32'h12, 32'h00001234);
    n_checks++;
    if (obs_we !== 4'b1100 || obs_din !== 32'h12341234) begin
      n_err++;
      $display("FAIL sh: we %b din %h exp 1100/12341234", obs_we, obs_din);
    end
  endtask

  task automatic test_errors;
    do_req(0, 1'b0, 3'd1, 32'h21, 32'h0);
    do_req(1, 1'b0, 3'd2, 32'h22, 32'h0);
    do_req(0, 1'b1, 3'd2, 32'h00010000, 32'h12345678);
    do_req(1, 1'b0, 3'd3, 32'h20, 32'h0);
    do_req(0, 1'b1, 3'd4, 32'h20, 32'h0);
    n_checks++;
    if (obs_err !== 1'b1 || obs_rdata !== 32'b0) begin
      n_err++;
      $display("FAIL st_f3: err %b rd %h exp 1/0", obs_err, obs_rdata);
    end
  endtask

  task automatic test_arbitration;
    int          exp_port [48];
    logic [31:0] exp_data [48];
    int          nxt;
    int          p;
    int          cnt [2];
    logic [1:0]  ev;
    for (int i = 0; i < 48; i++) exp_port[i] = -1;
    nxt = 0;
    cnt[0] = 0;
    cnt[1] = 0;
    apply_reset;
    bus.req_we = 2'b00;
    bus.req_funct3 = {3'd2, 3'd2};
    bus.req_addr = {32'h20, 32'h10};
    bus.req_valid = 2'b11;
    for (int c = 0; c < 42; c++) begin
      if (c == 34) bus.req_valid = 2'b00;
      #1;
      if (bus.req_ready != 2'b00) begin
        n_checks++;
        if (bus.req_ready !== 2'(1 << nxt)) begin
          n_err++;
          $display("FAIL rr_grant: got %b exp port %0d", bus.req_ready, nxt);
        end
        p = bus.req_ready[1] ? 1 : 0;
        cnt[p]++;
        exp_port[c+2] = p;
        exp_data[c+2] = exp_load(3'd2, p ? 32'h20 : 32'h10);
        nxt = 1 - nxt;
      end
      ev = (exp_port[c] >= 0) ? 2'(1 << exp_port[c]) : 2'b00;
      n_checks++;
      if (bus.rsp_valid !== ev) begin
        n_err++;
        $display("FAIL rr_vld: cyc %0d got %b exp %b", c, bus.rsp_valid, ev);
      end
      if (ev != 2'b00) begin
        n_checks++;
        if (bus.rsp_rdata !== exp_data[c]) begin
          n_err++;
          $display("FAIL rr_data: got %h exp %h", bus.rsp_rdata, exp_data[c]);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (cnt[0] < 5 || cnt[1] < 5) begin
      n_err++;
      $display("FAIL rr_starve: got %0d/%0d grants exp >=5 each",
               cnt[0], cnt[1]);
    end
  endtask

  task automatic test_midreset;
    logic [31:0] old;
    old = exp_load(3'd2, 32'h40);
    @(negedge clk);
    bus.req_valid[0] = 1'b1;
    bus.req_we[0] = 1'b1;
    bus.req_funct3[2:0] = 3'd2;
    bus.req_addr[31:0] = 32'h40;
    bus.req_wdata[31:0] = ~old;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL mr_hs: got %b exp 01", bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if (bus.ram_we !== 4'b1111) begin
      n_err++;
      $display("FAIL mr_access: got %b exp 1111", bus.ram_we);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.ram_we !== 4'b0 || bus.ram_addr !== 14'b0 ||
        bus.ram_din !== 32'b0 || bus.rsp_valid !== 2'b0 ||
        bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'b0) begin
      n_err++;
      $display("FAIL mr_clear: we %b a %h d %h vld %b exp all 0",
               bus.ram_we, bus.ram_addr, bus.ram_din, bus.rsp_valid);
    end
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 2'b00) begin
        n_err++;
        $display("FAIL mr_norsp: got %b exp 00", bus.rsp_valid);
      end
    end
    rst = 1'b0;
    bus.req_we = 2'b00;
    bus.req_funct3 = {3'd2, 3'd2};
    bus.req_addr = {32'h44, 32'h40};
    bus.req_valid = 2'b11;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) begin
      n_err++;
      $display("FAIL mr_tie: got %b exp 01", bus.req_ready);
    end
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 2'b00) begin
      n_err++;
      $display("FAIL mr_lat: got %b exp 00", bus.rsp_valid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 2'b01 || bus.rsp_rdata !== old) begin
      n_err++;
      $display("FAIL mr_load: vld %b rd %h exp 01/%h",
               bus.rsp_valid, bus.rsp_rdata, old);
    end
  endtask

  task automatic test_random;
    logic [2:0]  lf [5];
    logic [2:0]  f3;
    logic [31:0] a;
    bit          we;
    int          p;
    lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int n = 0; n < 80; n++) begin
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        f3 = 3'($urandom_range(0, 7));
      else if (we)
        f3 = 3'($urandom_range(0, 2));
      else
        f3 = lf[$urandom_range(0, 4)];
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0)
        a |= 32'h10000 << $urandom_range(0, 15);
      do_req(p, we, f3, a, $urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      ram[i] = $urandom;
      for (int b = 0; b < 4; b++)
        gmem[4*i + b] = ram[i][8*b +: 8];
    end
    bus.req_valid = 2'b00;
    bus.req_we = 2'b00;
    bus.req_funct3 = 6'b0;
    bus.req_addr = 64'b0;
    bus.req_wdata = 64'b0;
    test_reset;
    test_store_load;
    test_extract;
    test_errors;
    test_arbitration;
    test_midreset;
    test_random;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_ctrl.md
Name: riscv_dmem_ctrl

Overview:
- Two-requester access controller for the single-port 32-bit data RAM (14-bit word address, 1-cycle synchronous read).
- Arbitrates between the CPU load/store unit (port 0) and the debug/DMA master (port 1) using round-robin.
- Generates byte-lane write enables and lane-replicated store data.
- Performs load byte/half extraction with sign/zero extension.
- Flags misaligned, out-of-range and illegal-funct3 accesses without touching RAM.

Parameters:
- ADDR_W, 14, RAM word-address width. Valid byte addresses are 0 .. 2^(ADDR_W+2)-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-port request valid; bit p = port p.
- req_ready  out  2  per-port accept.
- req_we  in  2  1 = store, 0 = load.
- req_funct3  in  6  port p in bits [3p+2:3p]; RISC-V funct3 encoding.
- req_addr  in  64  port p in bits [32p+31:32p]; byte address.
- req_wdata  in  64  store data, LSB-aligned.
- rsp_valid  out  2  one-cycle response pulse.
- rsp_rdata  out  32  formatted load data; shared by both ports, qualified by rsp_valid.
- rsp_err  out  1  error flag for the current response.
- ram_we  out  4  byte write enables to RAM.
- ram_addr  out  ADDR_W  RAM word address.
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data, valid the cycle after address capture.

Behaviour:
- Reset: all outputs 0. state=IDLE. last_grant=1, so port 0 wins the first tie.
- States: IDLE, ACCESS, RESP.

IDLE:
- Arbitration:
  - If only one req_valid is set, that port is granted.
  - If both are set, the port != last_grant is granted.
- Grant effects: req_ready[g]=1, combinational from req_valid. The request is latched on that edge, and last_grant<=g.
- Illegal cases:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: addr[31:ADDR_W+2]!=0.
  - Illegal funct3 for a load: 011, 110, 111.
  - Illegal funct3 for a store: anything other than 000/001/010.
- Next state: RESP with err=1 for an illegal request, otherwise ACCESS.
- If no request is valid, stay in IDLE; req_ready=0.

ACCESS (1 cycle):
- Drive ram_addr=addr[ADDR_W+1:2] from registers.
- SW: ram_we=1111, ram_din=wdata.
- SH: ram_we=0011<<addr[1:0], ram_din={2{wdata[15:0]}}.
- SB: ram_we=0001<<addr[1:0], ram_din={4{wdata[7:0]}}.
- Loads: ram_we=0.
- Next state: RESP.

RESP (1 cycle):
- rsp_valid[owner]=1.
- rsp_err=latched err.
- Load with no error: sel = ram_dout >> (8*addr[1:0]).
  - LB: sign-extend sel[7:0].
  - LBU: zero-extend sel[7:0].
  - LH / LHU: sign- / zero-extend sel[15:0].
  - LW: sel.
- Store or error: rsp_rdata=0.
- Next state: IDLE.

Outside the active cycles:
- ram_we, rsp_valid, rsp_err and rsp_rdata are 0 outside ACCESS/RESP.
- ram_addr and ram_din hold their last value.

Latency and throughput:
- Handshake to rsp_valid: 2 cycles for a legal access, 1 cycle for an error.
- One outstanding request. Peak throughput is 1 access per 3 cycles.
- There is no response backpressure; requesters must accept rsp_valid.

Requester rules:
- A requester holds valid/fields stable until it sees ready.
- Fields are sampled only on the handshake edge.
- Changing fields later has no effect.

Mid-operation reset:
- Reset asserted in any state returns to IDLE immediately and clears the outputs.
- A RAM write already captured stays written. No response is produced.

Test Plan:
- Port 0 SW addr=0x10, wdata=0xDEADBEEF, then LW addr=0x10 -> ACCESS cycle shows ram_we=1111, ram_addr=4; the load's rsp_rdata=0xDEADBEEF 2 cycles after its handshake, rsp_err=0.
- With word 0x10 = 0x80FF7F01, loads:
  - LB 0x12 -> 0xFFFFFFFF.
  - LBU 0x13 -> 0x00000080.
  - LH 0x10 -> 0x00007F01.
  - LHU 0x12 -> 0x000080FF.
  - SB 0x11 wdata=0xAB -> ram_we=0010, ram_din=0xABABABAB.
- Both ports valid continuously with loads from reset -> grants alternate 0,1,0,1. Each rsp_valid bit pulses only for its owner; no port is starved.
- LH addr=0x21, LW addr=0x22, SW addr=0x00010000 (ADDR_W=14), load funct3=011 -> each responds after 1 cycle with rsp_err=1 and rsp_rdata=0; ram_we stays 0000 throughout.
- Assert rst during ACCESS of SW 0x40 -> outputs 0 at once, state IDLE, no rsp_valid. After release, a tie grants port 0 first.
